// File: rtl/gray_step_sequencer.sv
// Steps a WIDTH-bit position toward a latched target, one step every DIV cycles,
// and drives its registered Gray encoding on Y. Define GRAY_SEQ_SHORTEST_EN for shortest-path direction.
module gray_step_sequencer #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DIV   = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             down_req,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             step,
  output logic             down,
  output logic [WIDTH-1:0] pos,
  output logic [WIDTH-1:0] Y
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pos_q, pos_d, y_q, tgt_q, tgt_d, pos_next;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              down_q, down_d, step_q, step_d;
  logic              dir_sel;

`ifdef GRAY_SEQ_SHORTEST_EN
  logic [WIDTH-1:0] d_up, d_dn;
  logic             unused_down_req;
  assign d_up            = target - pos_q;
  assign d_dn            = pos_q - target;
  // Tie goes up.
  assign dir_sel         = (d_dn < d_up);
  assign unused_down_req = down_req;
`else
  assign dir_sel = down_req;
`endif

  assign pos_next = down_q ? (pos_q - WIDTH'(1)) : (pos_q + WIDTH'(1));

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    down_d  = down_q;
    step_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tgt_d  = target;
          down_d = dir_sel;
          if (target == pos_q) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            cnt_d   = Reload;
          end
        end
      end
      StRun: begin
        // Abort wins over a step due on the same edge.
        if (abort) begin
          state_d = StDone;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          pos_d  = pos_next;
          step_d = 1'b1;
          if (pos_next == tgt_q) begin
            state_d = StDone;
          end else begin
            cnt_d = Reload;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      pos_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      down_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      y_q     <= pos_d ^ (pos_d >> 1);
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      down_q  <= down_d;
      step_q  <= step_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign step = step_q;
  assign down = down_q;
  assign pos  = pos_q;
  assign Y    = y_q;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Self-checking bench for gray_step_sequencer (WIDTH=3, DIV=4): move table with a step
// scoreboard, plus abort, ignored-restart and mid-move reset sequences.
module tb_gray_step_sequencer;

  localparam int DIV = 4;

  logic       CLK = 1'b0;
  logic       RESET_N, start, down_req, abort;
  logic [2:0] target;
  logic       busy, done, step, down;
  logic [2:0] pos, Y;

  gray_step_sequencer #(.WIDTH(3), .DIV(DIV)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .target(target), .down_req(down_req),
    .abort(abort), .busy(busy), .done(done), .step(step), .down(down), .pos(pos), .Y(Y)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] tgt;
    logic       dreq;
    logic       exp_down;
    int         steps;
    logic [2:0] exp_pos;
  } vec_t;

  typedef struct {
    int         t;
    logic [2:0] y;
    logic [2:0] p;
  } sb_t;

  vec_t       vecs[11];
  sb_t        sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [2:0] cur_pos;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_move(input vec_t v, input int idx);
    logic [2:0] p;
    sb_t        e;
    bit         seen_done;
    p = cur_pos;
    for (int k = 1; k <= v.steps; k++) begin
      p = v.exp_down ? p - 3'd1 : p + 3'd1;
      sb.push_back('{t: k * DIV, y: p ^ (p >> 1), p: p});
    end
    start = 1'b1; target = v.tgt; down_req = v.dreq;
    seen_done = 1'b0;
    for (int t = 0; t < 40 && !seen_done; t++) begin
      @(negedge CLK);
      if (t == 0) start = 1'b0;
      if (step) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d unexpected step t=%0d", idx, t), 1, 0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d step time", idx), t, e.t);
          chk($sformatf("v%0d step Y", idx), int'(Y), int'(e.y));
          chk($sformatf("v%0d step pos", idx), int'(pos), int'(e.p));
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk($sformatf("v%0d done time", idx), t, v.steps * DIV);
        chk($sformatf("v%0d missing steps", idx), sb.size(), 0);
        chk($sformatf("v%0d down", idx), int'(down), int'(v.exp_down));
        chk($sformatf("v%0d final pos", idx), int'(pos), int'(v.exp_pos));
        chk($sformatf("v%0d final Y", idx), int'(Y), int'(v.exp_pos ^ (v.exp_pos >> 1)));
        chk($sformatf("v%0d busy at done", idx), int'(busy), 1);
      end
    end
    if (!seen_done) chk($sformatf("v%0d done timeout", idx), 0, 1);
    sb.delete();
    @(negedge CLK);
    chk($sformatf("v%0d busy after done", idx), int'(busy), 0);
    chk($sformatf("v%0d done one cycle", idx), int'(done), 0);
    cur_pos = v.exp_pos;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{tgt: 3'd3, dreq: 1'b0, exp_down: 1'b0, steps: 3, exp_pos: 3'd3};
    vecs[1]  = '{tgt: 3'd1, dreq: 1'b1, exp_down: 1'b1, steps: 2, exp_pos: 3'd1};
    vecs[2]  = '{tgt: 3'd3, dreq: 1'b0, exp_down: 1'b0, steps: 2, exp_pos: 3'd3};
`ifdef GRAY_SEQ_SHORTEST_EN
    vecs[3]  = '{tgt: 3'd1, dreq: 1'b0, exp_down: 1'b1, steps: 2, exp_pos: 3'd1};
    vecs[4]  = '{tgt: 3'd7, dreq: 1'b0, exp_down: 1'b1, steps: 2, exp_pos: 3'd7};
    vecs[9]  = '{tgt: 3'd6, dreq: 1'b1, exp_down: 1'b0, steps: 4, exp_pos: 3'd6};
`else
    vecs[3]  = '{tgt: 3'd1, dreq: 1'b0, exp_down: 1'b0, steps: 6, exp_pos: 3'd1};
    vecs[4]  = '{tgt: 3'd7, dreq: 1'b0, exp_down: 1'b0, steps: 6, exp_pos: 3'd7};
    vecs[9]  = '{tgt: 3'd6, dreq: 1'b1, exp_down: 1'b1, steps: 4, exp_pos: 3'd6};
`endif
    vecs[5]  = '{tgt: 3'd0, dreq: 1'b0, exp_down: 1'b0, steps: 1, exp_pos: 3'd0};
    vecs[6]  = '{tgt: 3'd7, dreq: 1'b1, exp_down: 1'b1, steps: 1, exp_pos: 3'd7};
    vecs[7]  = '{tgt: 3'd2, dreq: 1'b0, exp_down: 1'b0, steps: 3, exp_pos: 3'd2};
    vecs[8]  = '{tgt: 3'd2, dreq: 1'b0, exp_down: 1'b0, steps: 0, exp_pos: 3'd2};
    vecs[10] = '{tgt: 3'd0, dreq: 1'b0, exp_down: 1'b0, steps: 2, exp_pos: 3'd0};

    RESET_N = 1'b0; start = 1'b0; target = 3'd0; down_req = 1'b0; abort = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset pos", int'(pos), 0);
    chk("reset Y", int'(Y), 0);
    chk("reset busy/done/step/down", int'({busy, done, step, down}), 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("post-reset busy/done/step", int'({busy, done, step}), 0);
    chk("post-reset pos", int'(pos), 0);
    cur_pos = 3'd0;

    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort in idle busy", int'(busy), 0);
    chk("abort in idle done", int'(done), 0);

    for (int i = 0; i < 11; i++) do_move(vecs[i], i);

    // Abort just before the 2nd step; a mid-move start toward pos 1 must not retarget.
    start = 1'b1; target = 3'd6; down_req = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      if (t == 0) start = 1'b0;
      if (t == 4) begin
        chk("abort seq step1", int'(step), 1);
        chk("abort seq step1 pos", int'(pos), 1);
        chk("abort seq no retarget", int'({done, busy}), 1);
      end
      if (t > 4 && t < 8) chk($sformatf("abort seq quiet t=%0d", t), int'({step, done}), 0);
      if (t == 8) begin
        chk("abort done", int'(done), 1);
        chk("abort no step", int'(step), 0);
        chk("abort pos", int'(pos), 1);
        chk("abort Y", int'(Y), 1);
      end
      if (t == 9) chk("abort busy low", int'(busy), 0);
      if (t == 2) begin start = 1'b1; target = 3'd1; end
      if (t == 3) begin start = 1'b0; target = 3'd6; end
      if (t == 7) abort = 1'b1;
      if (t == 8) abort = 1'b0;
    end

    // Reset after the first step of a move from pos 1 toward 5.
    start = 1'b1; target = 3'd5; down_req = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK);
      if (t == 0) start = 1'b0;
    end
    chk("rst seq pos before reset", int'(pos), 2);
    RESET_N = 1'b0;
    #1;
    chk("rst seq pos", int'(pos), 0);
    chk("rst seq Y", int'(Y), 0);
    chk("rst seq busy/step", int'({busy, step}), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("rst seq no done", int'(done), 0);
    end
    RESET_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rst seq idle after release", int'({busy, done, step}), 0);
    end
    chk("rst seq pos after release", int'(pos), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_step_sequencer.md
Name: gray_step_sequencer

Overview:
- Controller that moves a Gray-coded 3-bit (parameterisable) position to a requested target, one up/down step at a time, at a programmable step rate.
- Owns the position register; exposes the binary position and its Gray encoding Y.
- Sits between a command source (start/target handshake) and position-indicator or encoder-emulation logic that consumes Y and the per-step strobe.

Parameters:
- WIDTH, 3, position width in bits; position wraps modulo 2^WIDTH.
- DIV, 4, clock cycles per step; legal range DIV >= 1.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- start  input  1  command request; sampled only in IDLE.
- target  input  WIDTH  binary target position; sampled with start.
- down_req  input  1  requested direction when shortest-path is compiled out (1 = down); sampled with start.
- abort  input  1  terminates a move in progress.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse when a move ends, whether completed or aborted.
- step  output  1  one-cycle pulse on each position change.
- down  output  1  direction of the current or last move.
- pos  output  WIDTH  binary position.
- Y  output  WIDTH  Gray code of pos (pos ^ (pos >> 1)), registered.

Behaviour:
- Reset (asynchronous, RESET_N low):
  - state = IDLE.
  - pos = 0, Y = 0, busy = 0, done = 0, step = 0, down = 0.
  - Divider count = 0, latched target = 0.
- States: IDLE, RUN, DONE. busy is decoded as (state != IDLE). done is high exactly when state == DONE.
- IDLE, start = 1 sampled at edge E0:
  - Latch target and direction.
  - If target == pos: go to DONE. Zero steps; done is high in the cycle after E0.
  - Otherwise: go to RUN and load divider count = DIV-1.
- IDLE, start = 0: stay in IDLE. abort is ignored in IDLE.
- RUN, each edge:
  - If abort = 1: go to DONE. No step occurs at that edge. pos and Y hold. abort has priority over a coincident step.
  - Else if divider count != 0: decrement the count.
  - Else (count == 0):
    - pos = pos - 1 if down, else pos + 1, modulo 2^WIDTH (7->0 wraps up, 0->7 wraps down).
    - Y is updated at the same edge from the new pos.
    - step = 1 for that cycle.
    - If the new pos == latched target: go to DONE. Otherwise reload the count with DIV-1.
- Timing:
  - The k-th step occurs at edge E0 + k*DIV.
  - For an N-step move, done is high in the cycle after edge E0 + N*DIV.
  - busy falls one cycle later.
- DONE: done = 1 for one cycle, then IDLE unconditionally. start is ignored while in DONE.
- start asserted while busy is ignored. target and down_req changes during a move have no effect.
- step and done are registered outputs. step is never high in the same cycle as done, except on the final step. On the final step, step is high in the cycle after the last edge's update, aligned with the transition into DONE.
- Y always equals gray(pos) for the current cycle. Exactly one bit of Y changes per step.
- Reset asserted mid-move returns to reset values immediately. No done pulse is generated.

Optional Feature:
- Macro: GRAY_SEQ_SHORTEST_EN.
- Defined:
  - down_req is ignored.
  - d_up = (target - pos) mod 2^WIDTH; d_dn = (pos - target) mod 2^WIDTH.
  - down = (d_dn < d_up); a tie selects up.
- Not defined: down = down_req as sampled with start. The move always proceeds in the requested direction, wrapping as needed.

Test Plan (WIDTH = 3, DIV = 4):
- Reset, then release RESET_N -> pos = 0, Y = 000, busy = 0, done = 0, step = 0. Assert RESET_N low mid-move (after 1 step) -> pos = 0, Y = 000, busy = 0 immediately, no done pulse.
- From pos 0, start with target = 3, down_req = 0 -> step pulses at edges E0+4, E0+8, E0+12. Y sequence 001, 011, 010. done high one cycle after edge E0+12. busy low one cycle after that.
- From pos 3, start with target = 1 and down_req = 1 -> down = 1, 2 steps, Y 011 -> 001. With macro off and down_req = 0 -> up, 6 steps through 7->0 wrap, Y ends 001. With macro on and down_req = 0 -> still down, 2 steps.
- Wrap-around: from pos 7 (Y = 100), start with target = 0, down_req = 0 -> 1 step, Y = 000, done after edge E0+4. From pos 0, target = 7, down_req = 1 -> Y = 100 after 1 step.
- From pos 2, start with target = 2 -> zero steps, done high in the cycle after E0, pos and Y unchanged.
- Start with target = 6 from pos 0 (up), assert abort at the cycle before the 2nd step -> pos = 1, Y = 001, no 2nd step, done pulse follows. A start pulse during the move is ignored: no retrigger, and the target is unchanged.
